// File: rtl/snn_pkg.sv
// snn_pkg: shared definitions for the spiking-neuron fixed-point stages.
//   - Q15.16 sign-magnitude format: bit 31 sign, [30:16] integer, [15:0] fraction
//   - signed zero constants
//   - spike detector FSM state encoding
//   - sm_to_twos(): maps a sign-magnitude word onto a two's-complement value
//     so ordinary signed compares give the sign-magnitude ordering
package snn_pkg;

  localparam int FP_W     = 32;
  localparam int FRAC_W   = 16;
  localparam int SIGN_BIT = 31;

  localparam logic [FP_W-1:0] SM_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] SM_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    FIRING  = 2'd1,
    REFRACT = 2'd2
  } spike_state_e;

  // Magnitude is 31 bits, so its negation always fits in 32-bit signed.
  // Both +0 and -0 map to 0, which makes them compare equal.
  function automatic logic signed [FP_W-1:0] sm_to_twos(input logic [FP_W-1:0] x);
    logic signed [FP_W-1:0] mag;
    mag = $signed({1'b0, x[SIGN_BIT-1:0]});
    return x[SIGN_BIT] ? -mag : mag;
  endfunction

endpackage

// File: rtl/spike_detector_if.sv
// spike_detector_if: ISI output channel of the spike detector.
//   isi_valid    : isi holds an unconsumed interval
//   isi_ready    : consumer accepts isi when high together with isi_valid
//   isi          : inter-spike interval in samples
//   isi_overflow : sticky, an interval was dropped because the buffer was full
// master = detector side, slave = consumer side.
interface spike_detector_if #(
  parameter int ISI_W = 16
) ();

  logic             isi_valid;
  logic             isi_ready;
  logic [ISI_W-1:0] isi;
  logic             isi_overflow;

  modport master (output isi_valid, output isi, output isi_overflow, input isi_ready);
  modport slave  (input isi_valid, input isi, input isi_overflow, output isi_ready);

endinterface

// File: rtl/sm_compare.sv
// sm_compare: combinational sign-magnitude comparator.
//   a, b : Q15.16 sign-magnitude operands
//   lt   : a <  b
//   ge   : a >= b
module sm_compare
  import snn_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            lt,
  output logic            ge
);

  always_comb begin
    lt = sm_to_twos(a) < sm_to_twos(b);
    ge = !lt;
  end

endmodule

// File: rtl/spike_detector.sv
// spike_detector: threshold/hysteresis/refractory spike detector with
// inter-spike-interval measurement.
//   clock, reset_n  : rising-edge clock, async active-low reset
//   v_valid, v      : membrane-voltage sample stream (Q15.16 sign-magnitude)
//   spike           : one-cycle pulse per detected spike
//   spike_count     : spikes since reset, wrapping
//   isi_port        : ISI valid/ready channel (spike_detector_if.master)
// Build option: define SPIKE_DETECTOR_ISI_EN to include the ISI counter and
// output buffer; otherwise the ISI channel outputs are tied to 0.
//
// state   | meaning
// ARMED   | waiting for v >= THRESHOLD; crossing fires a spike
// FIRING  | spike emitted, waiting for v < REARM
// REFRACT | counting down refr_cnt samples, crossings ignored
module spike_detector
  import snn_pkg::*;
#(
  parameter logic [FP_W-1:0] THRESHOLD  = 32'h0000_0000,
  parameter logic [FP_W-1:0] REARM      = 32'h8000_4CCD,
  parameter int              REFRACTORY = 8,
  parameter int              ISI_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              v_valid,
  input  logic [FP_W-1:0]   v,
  output logic              spike,
  output logic [15:0]       spike_count,
  spike_detector_if.master  isi_port
);

  localparam int REFR_W = (REFRACTORY > 1) ? $clog2(REFRACTORY + 1) : 1;

  spike_state_e      state_q, state_d;
  logic [REFR_W-1:0] refr_cnt_q, refr_cnt_d;
  logic              fire;
  logic              ge_thr, lt_rearm;
  logic              unused_lt_thr, unused_ge_rearm;

  sm_compare u_cmp_thr (
    .a  (v),
    .b  (THRESHOLD),
    .lt (unused_lt_thr),
    .ge (ge_thr)
  );

  sm_compare u_cmp_rearm (
    .a  (v),
    .b  (REARM),
    .lt (lt_rearm),
    .ge (unused_ge_rearm)
  );

  always_comb begin
    state_d    = state_q;
    refr_cnt_d = refr_cnt_q;
    fire       = 1'b0;
    if (v_valid) begin
      case (state_q)
        ARMED: begin
          if (ge_thr) begin
            fire    = 1'b1;
            state_d = FIRING;
          end
        end
        FIRING: begin
          if (lt_rearm) begin
            if (REFRACTORY == 0) begin
              state_d = ARMED;
            end else begin
              refr_cnt_d = REFR_W'(REFRACTORY);
              state_d    = REFRACT;
            end
          end
        end
        REFRACT: begin
          refr_cnt_d = refr_cnt_q - 1'b1;
          if (refr_cnt_q == REFR_W'(1)) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARMED;
      refr_cnt_q  <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state_q     <= state_d;
      refr_cnt_q  <= refr_cnt_d;
      spike       <= fire;
      spike_count <= spike_count + 16'(fire);
    end
  end

`ifdef SPIKE_DETECTOR_ISI_EN
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_inc, isi_q;
  logic             first_q, isi_valid_q, isi_ovf_q;
  logic             new_isi, consume;

  // isi_cnt counts samples since the previous spike, so the spike sample
  // itself is the +1 that closes the interval.
  assign isi_cnt_inc = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;
  assign new_isi     = fire && !first_q;
  assign consume     = isi_valid_q && isi_port.isi_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      isi_cnt_q   <= '0;
      first_q     <= 1'b1;
      isi_valid_q <= 1'b0;
      isi_q       <= '0;
      isi_ovf_q   <= 1'b0;
    end else begin
      if (v_valid) isi_cnt_q <= fire ? '0 : isi_cnt_inc;
      if (fire) first_q <= 1'b0;
      if (new_isi && (!isi_valid_q || consume)) begin
        isi_q       <= isi_cnt_inc;
        isi_valid_q <= 1'b1;
      end else if (new_isi) begin
        isi_ovf_q <= 1'b1;
      end else if (consume) begin
        isi_valid_q <= 1'b0;
      end
    end
  end

  assign isi_port.isi_valid    = isi_valid_q;
  assign isi_port.isi          = isi_q;
  assign isi_port.isi_overflow = isi_ovf_q;
`else
  logic unused_isi_ready;
  assign unused_isi_ready      = isi_port.isi_ready;
  assign isi_port.isi_valid    = 1'b0;
  assign isi_port.isi          = '0;
  assign isi_port.isi_overflow = 1'b0;
`endif

endmodule

// File: doc/spike_detector.md
# spike_detector

Downstream stage of the `wilson` neuron. Consumes the membrane-voltage sample stream `v` in the team's 32-bit sign-magnitude Q15.16 format. Emits a one-cycle spike pulse per action potential, using threshold, hysteresis and a refractory window. Measures the inter-spike interval (ISI) in samples and hands it to a consumer over a valid/ready port.

## Interface
- `THRESHOLD`, 32'h00000000 (+0.0): fire level, sign-magnitude Q15.16
- `REARM`, 32'h80004CCD (−0.3): level `v` must drop strictly below to leave FIRING
- `REFRACTORY`, 8: samples ignored after re-arm crossing; 0 = none
- `ISI_W`, 16: ISI and counter width
- `clock` in 1: rising-edge clock
- `reset_n` in 1: asynchronous, active-low reset
- `v_valid` in 1: `v` holds a new sample this cycle
- `v` in 32: membrane voltage, bit 31 sign, [30:16] integer, [15:0] fraction
- `spike` out 1: one-cycle pulse per detected spike
- `spike_count` out 16: spikes since reset, wraps at 16'hFFFF→0
- `isi_valid` out 1: `isi` holds an unconsumed interval
- `isi_ready` in 1: consumer accepts `isi` when high with `isi_valid`
- `isi` out ISI_W: samples between the two most recent spikes, saturating
- `isi_overflow` out 1: sticky; an interval was dropped because the buffer was full

## Operation
- Comparison is sign-magnitude.
  - +0 (32'h00000000) and −0 (32'h80000000) compare equal.
  - Negative < positive; among negatives, larger magnitude is smaller.
- Only cycles with `v_valid`=1 advance anything. With `v_valid`=0, all state, counters and `spike` hold or clear as below.
- FSM states:
  - ARMED (reset state): `v` ≥ THRESHOLD → spike, go FIRING.
  - FIRING: `v` < REARM → if REFRACTORY=0 go ARMED, else load `refr_cnt`=REFRACTORY and go REFRACT.
  - REFRACT: decrement `refr_cnt` per sample; the sample that brings it to 0 moves to ARMED. Crossings during REFRACT are ignored.
- ISI counter:
  - Increments per sample, saturating at 2^ISI_W−1.
  - On a spike sample at index n with previous spike at m, the reported interval is n−m, saturated.
  - Counter restarts so the next interval counts from n.
  - The first spike after reset produces no interval.
- Output buffer: single entry.
  - New interval with buffer empty, or with `isi_valid && isi_ready` in the same cycle: load it and hold `isi_valid`=1.
  - New interval with buffer full and not being consumed: drop it and set `isi_overflow`=1.
  - `isi` is stable while `isi_valid`=1 and `isi_ready`=0.
- `spike_count` increments on every spike, including the first.

## Timing
- Reset values: `spike`=0, `spike_count`=0, `isi_valid`=0, `isi`=0, `isi_overflow`=0. FSM=ARMED, ISI counter=0, `refr_cnt`=0, first-spike flag set.
- `reset_n` low mid-operation clears everything immediately (asynchronous). A pending ISI is lost.
- Latency: a sample captured at edge k produces `spike` during cycle k→k+1 (one cycle). `isi_valid`, `isi` and `spike_count` update on the same edge as `spike`.
- `spike` is never high for two consecutive cycles. At least one FIRING→exit sample separates spikes.
- `v_valid` may be high every cycle (full rate, as driven by `wilson`).

## Configuration
- `SPIKE_DETECTOR_ISI_EN` defined: ISI counter, output buffer and handshake are present as above.
- Not defined: ISI logic is removed.
  - `isi_valid`, `isi` and `isi_overflow` are tied to 0.
  - `isi_ready` is ignored.
  - Spike detection and `spike_count` are unchanged.

## Structure
- Shared package `snn_pkg` holds:
  - Q15.16 width constant FP_W=32 and field positions (sign bit 31, FRAC_W=16).
  - Constants SM_POS_ZERO and SM_NEG_ZERO.
  - The FSM state enum {ARMED, FIRING, REFRACT}.
- Sub-module `sm_compare`: combinational sign-magnitude `a < b` and `a >= b`. It is reusable by other fixed-point stages and is instantiated twice (threshold, rearm).

## Test plan
- Full-rate ramp −0.8, −0.4, +0.1, +0.3, −0.5, then hold −0.5 for 8 samples, REFRACTORY=8 → one `spike` on the cycle after the +0.1 sample, FSM back to ARMED after the 8th hold sample; `spike_count`=1, no `isi_valid`.
- Three spikes on sample indices 20, 50, 95 with `isi_ready`=1 → `isi` values 30 then 45; `spike_count`=3.
- Compare edge: `v`=32'h80000000 with THRESHOLD=+0 → spike; `v`=32'h80000001 → no spike.
- `isi_ready`=0 across two intervals → first held stable, second dropped, `isi_overflow`=1 stays set; ready in the same cycle as the third arrival → third loads, no further drop.
- Gap of 70000 samples with ISI_W=16 → `isi`=16'hFFFF.
- `reset_n` pulsed low while in REFRACT with `isi_valid`=1 → all outputs 0 immediately; the next spike gives no interval.
